// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary pointer helpers,
// used by both the read and write sides.
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 4;
  localparam int PTR_MAX_W    = 33;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Zero-extended Gray input keeps the upper result bits at zero.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop clock-domain synchronizer for Gray pointers, synchronous
// active-high reset. Shared by both sides of the asynchronous FIFO.
module fifo_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: pointer sync, empty flag and
// registered valid/ready output stage. FIFO_RD_AEMPTY_EN adds the raempty flag.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE      = DATASIZE_DEF,
  parameter int ADDRSIZE      = ADDRSIZE_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dvalid,
`ifdef FIFO_RD_AEMPTY_EN
  output logic                raempty,
`endif
  input  logic                dready
);

  localparam int PTR_W = ADDRSIZE + 1;

  logic [PTR_W-1:0]    wq2;
  logic [PTR_W-1:0]    rbin_q, rbin_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic                dvalid_q, dvalid_d;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic                pop;

  fifo_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (rclk),
    .rst (rrst),
    .d   (wptr),
    .q   (wq2)
  );

  // A pop moves one word from storage into dout whenever dout is free or being taken.
  always_comb begin
    pop      = ~rempty_q & (~dvalid_q | dready);
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, pop};
    rptr_d   = PTR_W'(bin2gray(PTR_MAX_W'(rbin_d)));
    rempty_d = (rptr_d == wq2);
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (pop) begin
      dout_d   = rdata_mem;
      dvalid_d = 1'b1;
    end else if (dvalid_q & dready) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      dvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
    end
  end

`ifdef FIFO_RD_AEMPTY_EN
  localparam logic [PTR_W-1:0] AEMPTY_LIMIT = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] wbin_sync;
  logic [PTR_W-1:0] fill_level;
  logic             raempty_q, raempty_d;

  // Modular pointer difference counts stored words across wraps.
  always_comb begin
    wbin_sync  = PTR_W'(gray2bin(PTR_MAX_W'(wq2)));
    fill_level = wbin_sync - rbin_d;
    raempty_d  = (fill_level <= AEMPTY_LIMIT);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      raempty_q <= 1'b1;
    end else begin
      raempty_q <= raempty_d;
    end
  end

  assign raempty = raempty_q;
`endif

  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;
  assign dvalid = dvalid_q;
  assign dout   = dout_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed steps plus a random phase,
// compared against a word-count/queue reference model. Honors FIFO_RD_AEMPTY_EN.
module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int SYNC  = 2;
  localparam int THR   = 2;
  localparam int DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [AW:0]   wptr;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          dready;
`ifdef FIFO_RD_AEMPTY_EN
  logic          raempty;
`endif

  logic [DW-1:0] mem [DEPTH];

  // Reference model state: counts of words written/popped/accepted plus data order.
  int            written, popped, accepted;
  int            hist[$];
  logic [DW-1:0] data_q[$];
  logic          m_rempty, m_dvalid, m_raempty;
  logic [DW-1:0] m_dout;
  int            dut_accepts;
  int            cycle;

  int errors = 0;
  int checks = 0;

  fifo_rd_ctrl #(
    .DATASIZE      (DW),
    .ADDRSIZE      (AW),
    .SYNC_STAGES   (SYNC),
    .AEMPTY_THRESH (THR)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr      (wptr),
    .rdata_mem (rdata_mem),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .dout      (dout),
    .dvalid    (dvalid),
`ifdef FIFO_RD_AEMPTY_EN
    .raempty   (raempty),
`endif
    .dready    (dready)
  );

  always #5 rclk = ~rclk;

  assign rdata_mem = mem[raddr];

  function automatic logic [31:0] grayOf(input int v);
    return 32'((v >> 1) ^ v);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("rempty", 32'(rempty), 32'(m_rempty));
    checkVal("dvalid", 32'(dvalid), 32'(m_dvalid));
    checkVal("dout",   32'(dout),   32'(m_dout));
    checkVal("rptr",   32'(rptr),   grayOf(popped % 32));
    checkVal("raddr",  32'(raddr),  32'(popped % DEPTH));
`ifdef FIFO_RD_AEMPTY_EN
    checkVal("raempty", 32'(raempty), 32'(m_raempty));
`endif
  endtask

  // One rclk edge: advance the model with the inputs sampled at that edge.
  task automatic applyStimulus();
    logic rst_s, rdy_s;
    int   wr_s, wq2_cnt;
    bit   pop;
    rst_s = rrst;
    rdy_s = dready;
    wr_s  = written;
    if (dvalid && dready && !rrst) dut_accepts++;
    @(posedge rclk);
    cycle++;
    if (rst_s) begin
      popped = 0; accepted = 0;
      m_rempty = 1'b1; m_dvalid = 1'b0; m_dout = '0; m_raempty = 1'b1;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(0);
    end else begin
      wq2_cnt = hist[0];
      pop = !m_rempty && (!m_dvalid || rdy_s);
      if (m_dvalid && rdy_s) accepted++;
      if (pop) begin
        m_dout   = data_q.pop_front();
        m_dvalid = 1'b1;
        popped++;
      end else if (m_dvalid && rdy_s) begin
        m_dvalid = 1'b0;
      end
      m_rempty  = (popped == wq2_cnt);
      m_raempty = ((wq2_cnt - popped) <= THR);
      hist.push_back(wr_s);
      void'(hist.pop_front());
    end
    #1;
    checkOutput();
  endtask

  task automatic writeWord(input logic [DW-1:0] data);
    mem[written % DEPTH] = data;
    data_q.push_back(data);
    written++;
    wptr = (AW+1)'(grayOf(written % 32));
  endtask

  function automatic bit canWrite();
    return (written - accepted) < DEPTH - 1;
  endfunction

  task automatic doReset(input int n);
    rrst    = 1'b1;
    written = 0;
    wptr    = '0;
    data_q.delete();
    for (int i = 0; i < n; i++) applyStimulus();
    rrst = 1'b0;
  endtask

  initial begin
    int start_acc, sent;
    cycle = 0; dut_accepts = 0;
    written = 0; popped = 0; accepted = 0;
    m_rempty = 1'b1; m_dvalid = 1'b0; m_dout = '0; m_raempty = 1'b1;
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    dready = 1'b0;
    rrst   = 1'b1;
    wptr   = '0;
    #1;

    $display("[TB] reset");
    doReset(2);
    checkVal("rst_rempty", 32'(rempty), 32'd1);
    checkVal("rst_dvalid", 32'(dvalid), 32'd0);
    checkVal("rst_dout",   32'(dout),   32'd0);
    checkVal("rst_rptr",   32'(rptr),   32'd0);
    checkVal("rst_raddr",  32'(raddr),  32'd0);

    $display("[TB] single word");
    writeWord(8'hA5);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkVal("sw_edge2_rempty", 32'(rempty), 32'd0);
    applyStimulus();
    checkVal("sw_edge3_dvalid", 32'(dvalid), 32'd1);
    checkVal("sw_edge3_dout",   32'(dout),   32'hA5);
    checkVal("sw_edge3_rptr",   32'(rptr),   32'b00001);
    checkVal("sw_edge3_rempty", 32'(rempty), 32'd1);
    dready = 1'b1;
    applyStimulus();
    checkVal("sw_taken_dvalid", 32'(dvalid), 32'd0);

    $display("[TB] backpressure");
    dready = 1'b0;
    writeWord(8'h11); applyStimulus();
    writeWord(8'h22); applyStimulus();
    writeWord(8'h33); applyStimulus();
    writeWord(8'h44); applyStimulus();
    for (int i = 0; i < 5; i++) applyStimulus();
    checkVal("bp_hold_dout", 32'(dout), 32'h11);
    checkVal("bp_hold_rptr", 32'(rptr), 32'b00011);
    dready = 1'b1;
    applyStimulus(); checkVal("bp_dout22", 32'(dout), 32'h22);
    applyStimulus(); checkVal("bp_dout33", 32'(dout), 32'h33);
    applyStimulus(); checkVal("bp_dout44", 32'(dout), 32'h44);
    applyStimulus(); checkVal("bp_drop_dvalid", 32'(dvalid), 32'd0);

    $display("[TB] wrap stream");
    start_acc = dut_accepts;
    sent = 0;
    for (int i = 0; i < 200; i++) begin
      if (sent < 40 && canWrite()) begin
        writeWord(8'(sent));
        sent++;
      end
      applyStimulus();
      if (sent == 40 && m_rempty && !m_dvalid && popped == written) break;
    end
    applyStimulus();
    checkVal("wrap_count", 32'(dut_accepts - start_acc), 32'd40);

    $display("[TB] reset mid-stream");
    dready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      writeWord(8'($urandom));
      applyStimulus();
    end
    for (int i = 0; i < 20 && (!m_dvalid || m_rempty); i++) applyStimulus();
    checkVal("mid_dvalid_before", 32'(dvalid), 32'd1);
    doReset(1);
    checkVal("mid_dvalid", 32'(dvalid), 32'd0);
    checkVal("mid_rempty", 32'(rempty), 32'd1);
    checkVal("mid_rptr",   32'(rptr),   32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      dready = ($urandom_range(0, 3) != 0);
      if (canWrite() && ($urandom_range(0, 2) != 0)) writeWord(8'($urandom));
      applyStimulus();
    end
    dready = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus();
    checkVal("drain_dvalid", 32'(dvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
